alu_seq: RTL

- Parametrised, multi-cycle successor to the datapath ALU.
- Keeps the existing 4-bit ctl encoding for all single-cycle ops and adds:
  - SLTU;
  - iterative signed/unsigned multiply and divide into HI/LO registers;
  - MFHI/MFLO reads;
  - a signed-overflow flag.
- Sits in EX, driven by the decode stage over a valid/ready handshake, result returned over a second valid/ready handshake.

---
 rtl/alu_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus iterative
// multiply/divide into HI/LO, with valid/ready handshakes on both sides.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             oflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_SUB   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd10;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_XOR   = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_RESP} state_t;

    state_t             state_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               is_div_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   out_reg;
    logic               zero_reg;
    logic               oflow_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic [WIDTH-1:0]   sum_w, diff_w, alu_res, a_mag, b_mag, quo_fix, rem_fix;
    logic               oflow_add, oflow_sub, alu_ofl, is_signed, accept;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

    // RESP doubles as the one-entry output skid: a new op may enter while
    // the current result is being taken.
    assign in_ready  = (state_reg == S_IDLE) | ((state_reg == S_RESP) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign zero      = zero_reg;
    assign oflow     = oflow_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

    always_comb begin
        sum_w     = a + b;
        diff_w    = a - b;
        oflow_add = (a[WIDTH-1] == b[WIDTH-1]) & (sum_w[WIDTH-1] != a[WIDTH-1]);
        oflow_sub = (a[WIDTH-1] != b[WIDTH-1]) & (diff_w[WIDTH-1] != a[WIDTH-1]);
        alu_res   = '0;
        alu_ofl   = 1'b0;
        case (ctl)
            OP_SUB:  begin alu_res = diff_w; alu_ofl = oflow_sub; end
            OP_ADD:  begin alu_res = sum_w;  alu_ofl = oflow_add; end
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff_w[WIDTH-1] ^ oflow_sub};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_MFHI: alu_res = hi_reg;
            OP_MFLO: alu_res = lo_reg;
            default: alu_res = '0;
        endcase

        is_signed = (ctl == OP_MULT) | (ctl == OP_DIV);
        a_mag     = (is_signed & a[WIDTH-1]) ? -a : a;
        b_mag     = (is_signed & b[WIDTH-1]) ? -b : b;

        // Shift-add: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

        // Restoring divide: acc = {remainder, remaining dividend / quotient bits}
        div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb_reg};
        if (!div_diff[WIDTH])
            div_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        quo_fix  = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            opb_reg       <= '0;
            cnt_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            is_div_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            zero_reg      <= 1'b1;
            oflow_reg     <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        case (ctl)
                            OP_MULT, OP_MULTU: begin
                                acc_reg       <= {{WIDTH{1'b0}}, b_mag};
                                opb_reg       <= a_mag;
                                neg_q_reg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r_reg     <= 1'b0;
                                is_div_reg    <= 1'b0;
                                cnt_reg       <= CNT_W'(WIDTH);
                                out_valid_reg <= 1'b0;
                                state_reg     <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                is_div_reg    <= 1'b1;
                                out_valid_reg <= 1'b0;
                                if (b == '0) begin
                                    // Divide by zero: hi=a, lo=all ones, no iteration
                                    acc_reg   <= {a, {WIDTH{1'b1}}};
                                    neg_q_reg <= 1'b0;
                                    neg_r_reg <= 1'b0;
                                    state_reg <= S_FIX;
                                end else begin
                                    acc_reg   <= {{WIDTH{1'b0}}, a_mag};
                                    opb_reg   <= b_mag;
                                    neg_q_reg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    neg_r_reg <= is_signed & a[WIDTH-1];
                                    cnt_reg   <= CNT_W'(WIDTH);
                                    state_reg <= S_DIV;
                                end
                            end
                            default: begin
                                out_reg       <= alu_res;
                                zero_reg      <= (alu_res == '0);
                                oflow_reg     <= alu_ofl;
                                out_valid_reg <= 1'b1;
                                state_reg     <= S_RESP;
                            end
                        endcase
                    end else if ((state_reg == S_RESP) && out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_reg <= mul_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1))
                        state_reg <= S_FIX;
                end
                S_DIV: begin
                    acc_reg <= div_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1))
                        state_reg <= S_FIX;
                end
                S_FIX: begin
                    if (is_div_reg) begin
                        hi_reg   <= rem_fix;
                        lo_reg   <= quo_fix;
                        out_reg  <= quo_fix;
                        zero_reg <= (quo_fix == '0);
                    end else begin
                        hi_reg   <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg   <= prod_fix[WIDTH-1:0];
                        out_reg  <= prod_fix[WIDTH-1:0];
                        zero_reg <= (prod_fix[WIDTH-1:0] == '0);
                    end
                    oflow_reg     <= 1'b0;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_RESP;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule
